// File: rtl/ps2_rx_fifo_apb_pkg.sv
// ps2_pkg: register map, STATUS bit positions and receiver FSM encoding.
package ps2_pkg;

   // Word offsets as decoded from paddr[3:2]
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_RSVD   = 2'd3;

   // STATUS bit positions; the FIFO count field starts at STAT_COUNT_LSB
   localparam int unsigned STAT_FRAME_ERR  = 0;
   localparam int unsigned STAT_PARITY_ERR = 1;
   localparam int unsigned STAT_OVERFLOW   = 2;
   localparam int unsigned STAT_EMPTY      = 3;
   localparam int unsigned STAT_FULL       = 4;
   localparam int unsigned STAT_COUNT_LSB  = 8;

   // Receiver FSM encoding
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DATA   = 2'd1;
   localparam logic [1:0] PARITY = 2'd2;
   localparam logic [1:0] STOP   = 2'd3;

   // Odd parity holds when data plus parity bit carry an odd number of ones
   function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
      return ^{b, p};
   endfunction

endpackage

// File: rtl/ps2_rx_fifo_apb_if.sv
// APB bus bundle for the PS/2 receiver; slave side is the peripheral.
interface ps2_rx_fifo_apb_if;
   logic [31:0] in_paddr;
   logic        in_psel;
   logic        in_penable;
   logic [2:0]  in_pprot;
   logic        in_pwrite;
   logic [31:0] in_pwdata;
   logic [3:0]  in_pstrb;
   logic        in_pready;
   logic [31:0] in_prdata;
   logic        in_pslverr;

   modport master (
      output in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
      input  in_pready, in_prdata, in_pslverr
   );

   modport slave (
      input  in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
      output in_pready, in_prdata, in_pslverr
   );
endinterface

// File: rtl/ps2_rx_fifo_apb_fifo.sv
// ps2_sync_fifo: single-clock FIFO with combinational head output.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ps2_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wptr_q, rptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem[rptr_q];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Storage write; contents need no reset since count gates visibility
   always_ff @(posedge clock) begin
      if (do_push) mem[wptr_q] <= wdata;
   end

   // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of 2)
   always_ff @(posedge clock) begin
      if (!reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + PTR_W'(1);
         if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/ps2_rx_fifo_apb.sv
// ps2_rx_fifo_apb: APB PS/2 keyboard receiver with scancode FIFO, sticky error
// flags, control register and a level interrupt.
module ps2_rx_fifo_apb
   import ps2_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned TIMEOUT_CYC  = 20000,
   parameter bit          CHECK_PARITY = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   ps2_rx_fifo_apb_if.slave apb,
   input  logic             ps2_clk,
   input  logic             ps2_data,
   output logic             irq
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

   logic [2:0]       clk_s, data_s;
   logic             fall, bit_in;
   logic [1:0]       state_q, state_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             par_q, par_d;
   logic [TMO_W-1:0] tmo_q;
   logic             tmo_hit;
   logic             push, set_frame, set_parity, set_ovf;
   logic             frame_err_q, parity_err_q, overflow_q;
   logic             enable_q, irq_en_q;
   logic             access, rd_data, wr_status, wr_ctrl, pop;
   logic [1:0]       reg_sel;
   logic [7:0]       fifo_head;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full, fifo_empty;
   logic [31:0]      status_word;
   logic             unused_bits;

   // Synchronisers preset to idle-high so no spurious fall follows reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         clk_s  <= 3'b111;
         data_s <= 3'b111;
      end else begin
         clk_s  <= {clk_s[1:0], ps2_clk};
         data_s <= {data_s[1:0], ps2_data};
      end
   end

   assign fall   = clk_s[2] & ~clk_s[1];
   assign bit_in = data_s[1];

   // Stall detection: a full timeout window without a fall abandons the frame
   assign tmo_hit = (state_q != IDLE) && (tmo_q == TMO_W'(TIMEOUT_CYC));

   // Frame FSM next state; push is combinational so the byte lands one cycle after the fall
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      push       = 1'b0;
      set_frame  = 1'b0;
      set_parity = 1'b0;
      if (tmo_hit) begin
         state_d   = IDLE;
         set_frame = 1'b1;
      end else if (fall) begin
         case (state_q)
            IDLE: begin
               if (!bit_in && enable_q) begin
                  state_d   = DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            DATA: begin
               shift_d   = {bit_in, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               par_d   = bit_in;
               state_d = STOP;
            end
            default: begin
               state_d = IDLE;
               if (!bit_in) set_frame = 1'b1;
               else if (CHECK_PARITY && !odd_parity_ok(shift_q, par_q)) set_parity = 1'b1;
               else push = 1'b1;
            end
         endcase
      end
   end

   // FSM and timeout counter state
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         tmo_q     <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         if (fall || tmo_hit || state_q == IDLE) tmo_q <= '0;
         else                                    tmo_q <= tmo_q + TMO_W'(1);
      end
   end

   // APB decode; reads of DATA pop only when something is there
   assign reg_sel   = apb.in_paddr[3:2];
   assign access    = apb.in_psel & apb.in_penable;
   assign rd_data   = access & ~apb.in_pwrite & (reg_sel == REG_DATA);
   assign wr_status = access & apb.in_pwrite & (reg_sel == REG_STATUS);
   assign wr_ctrl   = access & apb.in_pwrite & (reg_sel == REG_CTRL);
   assign pop       = rd_data & ~fifo_empty;
   assign set_ovf   = push & fifo_full & ~pop;

   ps2_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (shift_q),
      .rdata (fifo_head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Sticky flags (set beats W1C) and control register
   always_ff @(posedge clock) begin
      if (!reset) begin
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overflow_q   <= 1'b0;
         enable_q     <= 1'b1;
         irq_en_q     <= 1'b0;
      end else begin
         frame_err_q  <= set_frame |
                         (frame_err_q & ~(wr_status & apb.in_pwdata[STAT_FRAME_ERR]));
         parity_err_q <= set_parity |
                         (parity_err_q & ~(wr_status & apb.in_pwdata[STAT_PARITY_ERR]));
         overflow_q   <= set_ovf |
                         (overflow_q & ~(wr_status & apb.in_pwdata[STAT_OVERFLOW]));
         if (wr_ctrl) begin
            irq_en_q <= apb.in_pwdata[1];
            enable_q <= apb.in_pwdata[0];
         end
      end
   end

   // STATUS word assembly
   always_comb begin
      status_word                              = '0;
      status_word[STAT_COUNT_LSB +: CNT_W]     = fifo_count;
      status_word[STAT_FULL]                   = fifo_full;
      status_word[STAT_EMPTY]                  = fifo_empty;
      status_word[STAT_OVERFLOW]               = overflow_q;
      status_word[STAT_PARITY_ERR]             = parity_err_q;
      status_word[STAT_FRAME_ERR]              = frame_err_q;
   end

   // Read mux; DATA returns zero when the FIFO is empty
   always_comb begin
      apb.in_prdata = '0;
      case (reg_sel)
         REG_DATA:   if (!fifo_empty) apb.in_prdata = {23'd0, 1'b1, fifo_head};
         REG_STATUS: apb.in_prdata = status_word;
         REG_CTRL:   apb.in_prdata = {30'd0, irq_en_q, enable_q};
         default:    apb.in_prdata = '0;
      endcase
   end

   assign apb.in_pready  = 1'b1;
   assign apb.in_pslverr = access & (reg_sel == REG_RSVD);
   assign irq = irq_en_q & (~fifo_empty | frame_err_q | parity_err_q | overflow_q);

   assign unused_bits = ^{apb.in_paddr[31:4], apb.in_paddr[1:0], apb.in_pprot, apb.in_pstrb,
                          apb.in_pwdata[31:3]};

endmodule
